clock_div_prog: RTL

//   Multi-channel, runtime-programmable clock divider/strobe generator. Each channel divides
//   CLK_IN by its own period D, with per-channel enable, glitch-free ratio updates and
//   all-channel phase sync. Outputs a square wave and a one-cycle tick per channel.

---
 rtl/clock_div_prog_if.sv | 25 ++
 rtl/clock_div_prog.sv | 81 ++++++++
 2 files changed

// File: rtl/clock_div_prog_if.sv
// Host-side bundle for the programmable clock divider: enables, sync, period
// write port and the per-channel divided clock / tick outputs.
interface clock_div_prog_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DIV_W = 24,
  parameter int unsigned CH_W  = 4
);
  logic [N_CH-1:0]  EN;
  logic             SYNC;
  logic             WR_EN;
  logic [CH_W-1:0]  WR_CH;
  logic [DIV_W-1:0] WR_DIV;
  logic [N_CH-1:0]  CLK_OUT;
  logic [N_CH-1:0]  TICK_OUT;

  modport master (
    output EN, SYNC, WR_EN, WR_CH, WR_DIV,
    input  CLK_OUT, TICK_OUT
  );

  modport slave (
    input  EN, SYNC, WR_EN, WR_CH, WR_DIV,
    output CLK_OUT, TICK_OUT
  );
endinterface

// File: rtl/clock_div_prog.sv
// Multi-channel runtime-programmable clock divider with per-channel enable,
// glitch-free period updates at period boundaries and all-channel phase sync.
module clock_div_prog #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DIV_W       = 24,
  parameter int unsigned DEFAULT_DIV = 100000,
  parameter int unsigned CH_W        = 4
) (
  input  logic             CLK_IN,
  input  logic             RESET,
  clock_div_prog_if.slave  bus
);

  localparam int unsigned CNT_W = DIV_W;

  logic [DIV_W-1:0] pend_q [N_CH];
  logic [DIV_W-1:0] pend_d [N_CH];
  logic [DIV_W-1:0] act_q  [N_CH];
  logic [DIV_W-1:0] act_d  [N_CH];
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [N_CH-1:0]  en_q;
  logic [N_CH-1:0]  clk_q, clk_d;
  logic [N_CH-1:0]  tick_q, tick_d;

  // Next-state per channel; active period reloads only at a period boundary,
  // on sync, on enable rise, while stopped (D<2) or while disabled.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      pend_d[i] = pend_q[i];
      act_d[i]  = act_q[i];
      cnt_d[i]  = '0;
      clk_d[i]  = 1'b0;
      tick_d[i] = 1'b0;

      if (bus.WR_EN && (bus.WR_CH == CH_W'(i))) begin
        pend_d[i] = bus.WR_DIV;
      end

      if (!bus.EN[i]) begin
        act_d[i] = pend_q[i];
      end else if (!en_q[i] || bus.SYNC || (act_q[i] < DIV_W'(2)) ||
                   (cnt_q[i] == CNT_W'(act_q[i] - DIV_W'(1)))) begin
        act_d[i] = pend_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

      if (bus.EN[i] && (act_d[i] >= DIV_W'(2))) begin
        clk_d[i]  = (cnt_d[i] < CNT_W'(act_d[i] >> 1));
        tick_d[i] = (cnt_d[i] == '0);
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        pend_q[i] <= DIV_W'(DEFAULT_DIV);
        act_q[i]  <= DIV_W'(DEFAULT_DIV);
        cnt_q[i]  <= '0;
      end
      en_q   <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      en_q   <= bus.EN;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign bus.CLK_OUT  = clk_q;
  assign bus.TICK_OUT = tick_q;

endmodule
